// File: rtl/spi_master.sv
// spi_master: register-mapped SPI master, one 8-bit transfer at a time.
// Registers: 0 DATA, 1 CTRL, 2 DIV, 3 CS (active-low chip selects).
// Build option: define SPI_MASTER_IRQ_EN for the registered, maskable
// transfer-done interrupt; otherwise irq is tied low and CTRL[4] reads 0.
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | sck parked at CPOL, mosi high, waiting for a START write
// ST_SHIFT | 16 half-periods of sck, TX bits out / RX bits in
// ST_DONE  | one clk: RX byte to DATA, DONE flag set, back to idle
module spi_master #(
    parameter int NUM_CS      = 2,
    parameter int DIV_DEFAULT = 499
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        addr,
    input  logic [7:0]        mosi,
    output logic [7:0]        miso,
    input  logic              write,
    output logic [NUM_CS-1:0] spi_cs,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso,
    input  logic              sd_det,
    output logic              irq
);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [7:0]          r_data;
    logic [7:0]          r_rx;
    // DIV is 16 bits so the default (499) fits; the host writes the low byte.
    logic [15:0]         r_div;
    logic [15:0]         r_cnt;
    logic [NUM_CS-1:0]   r_cs;
    logic                r_cpol;
    logic                r_cpha;
    logic                r_lsb;
    logic                r_done;
    logic                r_phase;
    logic [3:0]          r_hcnt;
    logic [2:0]          r_oidx;
    logic                w_busy;
    logic                w_tick;
    logic                w_lead;
    logic                w_tx_bit;
    logic                w_irq_en_rd;
    logic                w_wr_data;
    logic                w_wr_ctrl;
    logic                w_wr_div;
    logic                w_wr_cs;
    logic                w_start;
    logic [7:0]          w_cs_rd;

    assign w_wr_data = write && (addr == 2'd0);
    assign w_wr_ctrl = write && (addr == 2'd1);
    assign w_wr_div  = write && (addr == 2'd2);
    assign w_wr_cs   = write && (addr == 2'd3);
    assign w_start   = w_wr_ctrl && mosi[0] && (r_state == ST_IDLE);

    // Half-period boundary; r_hcnt counts boundaries already passed, so an
    // even count means the upcoming boundary is a leading sck edge.
    assign w_tick   = (r_state == ST_SHIFT) && (r_cnt == r_div);
    assign w_lead   = ~r_hcnt[0];
    assign w_tx_bit = r_lsb ? r_data[r_oidx] : r_data[~r_oidx];
    assign spi_cs   = r_cs;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // FSM next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_start) w_next = ST_SHIFT;
            ST_SHIFT: if (w_tick && (r_hcnt == 4'd15)) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // FSM outputs: busy through DONE, sck/mosi only active while shifting
    always_comb begin
        w_busy   = (r_state != ST_IDLE);
        spi_sck  = r_cpol;
        spi_mosi = 1'b1;
        if (r_state == ST_SHIFT) begin
            spi_sck  = r_cpol ^ r_phase;
            spi_mosi = w_tx_bit;
        end
    end

    // Half-period timer, sck phase, output bit index and RX assembly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
            r_hcnt  <= '0;
            r_oidx  <= '0;
            r_rx    <= '0;
        end else if (r_state != ST_SHIFT) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
            r_hcnt  <= '0;
            r_oidx  <= '0;
        end else if (w_tick) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
            r_hcnt  <= r_hcnt + 4'd1;
            // Sample edge is leading for CPHA=0, trailing for CPHA=1.
            if (w_lead != r_cpha)
                r_rx <= r_lsb ? {spi_miso, r_rx[7:1]} : {r_rx[6:0], spi_miso};
            // Bit 0 is already on the line at entry; no advance after the last edge.
            else if ((r_hcnt != 4'd0) && (r_hcnt != 4'd15))
                r_oidx <= r_oidx + 3'd1;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // Host registers; DATA/DIV/mode bits frozen while a transfer is in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= 8'h00;
            r_div  <= 16'(DIV_DEFAULT);
            r_cs   <= '1;
            r_cpol <= 1'b0;
            r_cpha <= 1'b0;
            r_lsb  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            if (r_state == ST_DONE)
                r_data <= r_rx;
            else if (w_wr_data && !w_busy)
                r_data <= mosi;
            if (w_wr_div && !w_busy)
                r_div <= {8'h00, mosi};
            if (w_wr_cs)
                r_cs <= mosi[NUM_CS-1:0];
            if (w_wr_ctrl && !w_busy)
                {r_lsb, r_cpha, r_cpol} <= mosi[3:1];
            // Setting DONE wins over a simultaneous clear.
            if (r_state == ST_DONE)
                r_done <= 1'b1;
            else if (w_wr_ctrl && mosi[5])
                r_done <= 1'b0;
        end
    end

`ifdef SPI_MASTER_IRQ_EN
    logic r_irq_en;
    logic r_irq;

    // IRQ enable stays writable mid-transfer; irq is registered from the flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr_ctrl)
                r_irq_en <= mosi[4];
            r_irq <= r_done & r_irq_en;
        end
    end

    assign w_irq_en_rd = r_irq_en;
    assign irq         = r_irq;
`else
    assign w_irq_en_rd = 1'b0;
    assign irq         = 1'b0;
`endif

    // Host read mux
    always_comb begin
        w_cs_rd               = 8'h00;
        w_cs_rd[NUM_CS-1:0]   = r_cs;
        case (addr)
            2'd0:    miso = r_data;
            2'd1:    miso = {~sd_det, 1'b0, r_done, w_irq_en_rd, r_lsb, r_cpha, r_cpol, w_busy};
            2'd2:    miso = r_div[7:0];
            default: miso = w_cs_rd;
        endcase
    end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter: NUM_CS, default 2, number of chip-select outputs (1..8).
REQ-002 Parameter: DIV_DEFAULT, default 499, reset value of DIV register (half-period = DIV+1 clk cycles).
REQ-003 Port: clk  input  1  single system clock, all logic on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: addr  input  2  register select (0 DATA, 1 CTRL, 2 DIV, 3 CS).
REQ-006 Port: mosi  input  8  host write data.
REQ-007 Port: miso  output  8  host read data, combinational from addr.
REQ-008 Port: write  input  1  write strobe, one register write per high cycle.
REQ-009 Port: spi_cs  output  NUM_CS  chip selects, active low, driven from CS register.
REQ-010 Port: spi_sck  output  1  serial clock.
REQ-011 Port: spi_mosi  output  1  serial data out.
REQ-012 Port: spi_miso  input  1  serial data in.
REQ-013 Port: sd_det  input  1  card detect, active low.
REQ-014 Port: irq  output  1  transfer-done interrupt, level, active high.

Function
REQ-015 CTRL bits: [0] BUSY/START, [1] CPOL, [2] CPHA, [3] LSB_FIRST, [4] IRQ_EN, [5] DONE flag, [6] reserved reads 0, [7] read-only = !sd_det.
REQ-016 DATA write loads TX shift byte; DATA read returns last received byte (TX byte until first transfer completes).
REQ-017 CTRL write with bit0=1 while IDLE SHALL start a transfer next cycle; bits[4:1] latch; writing bit5=1 clears DONE.
REQ-018 While BUSY: DATA, DIV, and CTRL[3:1] writes SHALL be ignored; CTRL[4] and DONE-clear still apply; CS writes apply immediately.
REQ-019 FSM states IDLE, SHIFT, DONE; IDLE->SHIFT on start; SHIFT->DONE after 16 half-periods; DONE->IDLE after exactly one clk.
REQ-020 Half-period counter counts 0..DIV, reloads at DIV; counter held at 0 in IDLE; DIV=0 gives sck = clk/2.
REQ-021 spi_sck = CPOL in IDLE and DONE; toggles at each half-period boundary in SHIFT; exactly 8 full pulses per transfer.
REQ-022 CPHA=0: first bit on spi_mosi on entry to SHIFT; sample spi_miso on leading edges; shift out on trailing edges.
REQ-023 CPHA=1: shift out on leading edges; sample on trailing edges.
REQ-024 Bit order MSB first unless LSB_FIRST=1; RX byte assembled in same order.
REQ-025 spi_mosi = 1 when not in SHIFT.
REQ-026 In DONE: DATA <= RX byte, BUSY <= 0, DONE <= 1 (same cycle); simultaneous DONE-clear write loses to set.
REQ-027 Start write in DONE cycle is ignored; host must re-issue in IDLE.
REQ-028 spi_cs never changed by the FSM; software controls framing.

Reset
REQ-029 On rst: DATA=0x00, CTRL[5:0]=0, DIV=DIV_DEFAULT, CS=all ones, FSM=IDLE, counter=0, spi_sck=0, spi_mosi=1, irq=0.
REQ-030 rst asserted mid-transfer SHALL abort immediately with no DONE set; outputs take reset values asynchronously.

Configuration
REQ-031 Macro SPI_MASTER_IRQ_EN defined: irq = DONE & IRQ_EN, registered.
REQ-032 Macro SPI_MASTER_IRQ_EN undefined: irq tied 0, CTRL[4] reads 0 and ignores writes; DONE flag still functional.

Verification
REQ-033 DIV=1, mode0, MSB first, DATA=0xA5, slave returns 0x3C -> 8 sck pulses of 4 clk period, MOSI A5, DATA reads 0x3C, BUSY 0, DONE 1.
REQ-034 Mode3 (CPOL=1,CPHA=1), LSB first, TX 0x81, slave 0xF0 -> sck idles high, MOSI bits 1,0,0,0,0,0,0,1, RX 0xF0.
REQ-035 DATA write 0x55 and DIV write 7 during transfer -> ignored, transfer finishes at original rate, TX byte unchanged.
REQ-036 rst pulse at bit 4 of transfer -> spi_sck=0, spi_mosi=1, BUSY=0, DONE=0, DATA=0x00, CS=all ones.
REQ-037 IRQ_EN=1, transfer completes -> irq=1 one cycle after DONE; CTRL write 0x20 -> irq=0 next cycle; without macro irq stays 0.
REQ-038 sd_det=0 -> CTRL read bit7=1; CS write 0x02 -> spi_cs=2'b10 immediately, unaffected by transfer.
